// File: rtl/power_sched.sv
// -----------------------------------------------------------------------------
// power_sched
//   Round-robin scheduler that shares one iterative power engine among N_REQ
//   requesters. One job is in flight at a time: an operand is accepted, the
//   engine is started with a one-cycle pulse, its finished level is awaited
//   under a watchdog, and the result is returned with the requester index on
//   a valid/ready response port.
//
// Ports
//   i_clk          clock, rising edge
//   i_arst_n       asynchronous active-low reset
//   i_reqValid     per-requester operand valid
//   i_reqX         operands, requester k at [k*WIDTH +: WIDTH]
//   o_reqReady     one-hot accept, high only for the granted requester in IDLE
//   o_engStart     one-cycle start pulse to the engine
//   o_engX         operand to the engine (registered)
//   i_engResult    engine result
//   i_engFinished  engine done level
//   o_rspValid     response valid
//   o_rspId        requester index of the response
//   o_rspData      result (0 on error)
//   o_rspErr       engine timed out
//   i_rspReady     response consumer ready
//   o_busy         high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module power_sched #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                       i_clk,
    input  logic                       i_arst_n,
    input  logic [N_REQ-1:0]           i_reqValid,
    input  logic [N_REQ*WIDTH-1:0]     i_reqX,
    output logic [N_REQ-1:0]           o_reqReady,
    output logic                       o_engStart,
    output logic [WIDTH-1:0]           o_engX,
    input  logic [WIDTH-1:0]           i_engResult,
    input  logic                       i_engFinished,
    output logic                       o_rspValid,
    output logic [$clog2(N_REQ)-1:0]   o_rspId,
    output logic [WIDTH-1:0]           o_rspData,
    output logic                       o_rspErr,
    input  logic                       i_rspReady,
    output logic                       o_busy
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int WD_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_RESP
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [WIDTH-1:0]  r_x;
    logic [WD_W-1:0]   r_wd;
    logic              r_eng_start;
    logic              r_busy;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [WIDTH-1:0]  r_rsp_data;
    logic              r_rsp_err;

    logic              w_any;
    logic [ID_W-1:0]   w_grant;
    logic [WIDTH-1:0]  w_sel_x;

    // Circular priority search: the first valid requester at or after r_ptr.
    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin : grant_search
        int idx;
        idx     = 0;
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(r_ptr) + i) % N_REQ;
            if (!w_any && i_reqValid[idx]) begin
                w_any   = 1'b1;
                w_grant = ID_W'(idx);
            end
        end
        w_sel_x = i_reqX[int'(w_grant)*WIDTH +: WIDTH];
    end

    // Accept is combinational so the requester sees it in the same IDLE cycle.
    always_comb begin
        o_reqReady = '0;
        if (r_state == S_IDLE && w_any) begin
            o_reqReady[w_grant] = 1'b1;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_x         <= '0;
            r_wd        <= '0;
            r_eng_start <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id        <= w_grant;
                        r_x         <= w_sel_x;
                        r_eng_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_LAUNCH;
                    end
                end
                // i_engFinished still reflects the previous job here; it is
                // not looked at until the engine has seen the start pulse.
                S_LAUNCH: begin
                    r_eng_start <= 1'b0;
                    r_wd        <= '0;
                    r_state     <= S_BUSY;
                end
                // Finish has priority over a watchdog expiry in the same cycle.
                S_BUSY: begin
                    if (i_engFinished) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_data  <= i_engResult;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_RESP: begin
                    if (i_rspReady) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_id    <= '0;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b0;
                        r_busy      <= 1'b0;
                        r_ptr       <= (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_engStart = r_eng_start;
    assign o_engX     = r_x;
    assign o_busy     = r_busy;
    assign o_rspValid = r_rsp_valid;
    assign o_rspId    = r_rsp_id;
    assign o_rspData  = r_rsp_data;
    assign o_rspErr   = r_rsp_err;

endmodule

// File: tb/tb_power_sched.sv
// -----------------------------------------------------------------------------
// tb_power_sched
//   Self-checking bench for power_sched with a behavioural cube engine
//   (finished rises three cycles after the start pulse). Accepted requests
//   push an expected response into a scoreboard; responses pop and compare.
// -----------------------------------------------------------------------------
module tb_power_sched;

    localparam int N_REQ   = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_x = '0;
    logic [3:0]  o_reqReady;
    logic        o_engStart;
    logic [7:0]  o_engX;
    logic [7:0]  eng_result;
    logic        eng_finished;
    logic        o_rspValid;
    logic [1:0]  o_rspId;
    logic [7:0]  o_rspData;
    logic        o_rspErr;
    logic        rsp_ready = 1'b1;
    logic        o_busy;

    rsp_t sb_q[$];
    int   served_id[$];
    int   served_data[$];
    rsp_t last_rsp;
    int   n_vec = 0;
    int   n_err = 0;
    int   ptr_model = 0;
    bit   eng_hang = 1'b0;

    logic       eng_run;
    logic [1:0] eng_cnt;
    logic [7:0] eng_x;

    power_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk         (clk),
        .i_arst_n      (rst_n),
        .i_reqValid    (req_valid),
        .i_reqX        (req_x),
        .o_reqReady    (o_reqReady),
        .o_engStart    (o_engStart),
        .o_engX        (o_engX),
        .i_engResult   (eng_result),
        .i_engFinished (eng_finished),
        .o_rspValid    (o_rspValid),
        .o_rspId       (o_rspId),
        .o_rspData     (o_rspData),
        .o_rspErr      (o_rspErr),
        .i_rspReady    (rsp_ready),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] cube(input logic [7:0] x);
        return 8'((int'(x) * int'(x) * int'(x)) % 256);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural engine: start clears finished; result and finished appear
    // three cycles after the start cycle and then hold. eng_hang never finishes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_finished <= 1'b0;
            eng_result   <= '0;
            eng_run      <= 1'b0;
            eng_cnt      <= '0;
            eng_x        <= '0;
        end else if (o_engStart) begin
            eng_finished <= 1'b0;
            eng_run      <= !eng_hang;
            eng_cnt      <= 2'd2;
            eng_x        <= o_engX;
        end else if (eng_run) begin
            if (eng_cnt == 2'd1) begin
                eng_finished <= 1'b1;
                eng_result   <= cube(eng_x);
                eng_run      <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 2'd1;
            end
        end
    end

    // Scoreboard monitor: accepts push, response handshakes pop.
    always @(negedge clk) begin
        int   g;
        int   idx;
        rsp_t e;
        if (rst_n) begin
            if (o_reqReady != 4'd0) begin
                g = -1;
                for (int i = 0; i < N_REQ; i++) begin
                    idx = (ptr_model + i) % N_REQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                check("grant_onehot", 32'(o_reqReady), (g < 0) ? 32'd0 : (32'd1 << g));
                if (g >= 0) begin
                    e.id   = 2'(g);
                    e.data = eng_hang ? 8'd0 : cube(req_x[g*8 +: 8]);
                    e.err  = eng_hang;
                    sb_q.push_back(e);
                end
            end
            if (o_rspValid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_id",   32'(o_rspId),   32'(e.id));
                    check("rsp_data", 32'(o_rspData), 32'(e.data));
                    check("rsp_err",  32'(o_rspErr),  32'(e.err));
                    ptr_model = (int'(e.id) + 1) % N_REQ;
                end
                last_rsp.id   = o_rspId;
                last_rsp.data = o_rspData;
                last_rsp.err  = o_rspErr;
                served_id.push_back(int'(o_rspId));
                served_data.push_back(int'(o_rspData));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_reqReady[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!o_reqReady[k]) check("ready_wait", 32'd0, 32'd1);
    endtask

    task automatic wait_hs(input int cnt);
        int seen;
        int n;
        seen = 0;
        n    = 0;
        while (seen < cnt && n < 200) begin
            @(negedge clk);
            n++;
            if (o_rspValid && rsp_ready) seen++;
        end
        if (seen < cnt) check("hs_wait", 32'(seen), 32'(cnt));
    endtask

    // One job with rspReady high, checking the cycle-by-cycle latency.
    task automatic job_timed(input int k, input logic [7:0] x);
        req_valid[k]      = 1'b1;
        req_x[k*8 +: 8]   = x;
        wait_ready(k);
        check("c0_busy", 32'(o_busy), 32'd0);
        tick();
        req_valid[k] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check("job_busy",  32'(o_busy),     32'd1);
            check("job_start", 32'(o_engStart), (c == 1) ? 32'd1 : 32'd0);
            check("job_rspv",  32'(o_rspValid), (c == 5) ? 32'd1 : 32'd0);
            if (c == 1) check("job_engx", 32'(o_engX), 32'(x));
        end
        @(negedge clk);
        check("c6_busy", 32'(o_busy), 32'd0);
        tick();
    endtask

    initial begin
        int n;
        int exp_id[5];
        int exp_data[5];
        exp_id   = '{0, 1, 2, 3, 0};
        exp_data = '{1, 8, 27, 64, 1};

        // Reset state
        #12;
        check("rst_ready", 32'(o_reqReady), 32'd0);
        check("rst_start", 32'(o_engStart), 32'd0);
        check("rst_rspv",  32'(o_rspValid), 32'd0);
        check("rst_busy",  32'(o_busy),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: req0 X=3
        job_timed(0, 8'd3);
        check("t1_id", 32'(last_rsp.id), 32'd0);
        check("t1_data", 32'(last_rsp.data), 32'd27);
        check("t1_err", 32'(last_rsp.err), 32'd0);

        // 2: req2 X=7 -> 343 mod 256
        job_timed(2, 8'd7);
        check("t2_id", 32'(last_rsp.id), 32'd2);
        check("t2_data", 32'(last_rsp.data), 32'd87);

        // req3 X=4 brings the pointer back to 0
        job_timed(3, 8'd4);
        check("t2b_data", 32'(last_rsp.data), 32'd64);

        // 3: all valid continuously
        served_id.delete();
        served_data.delete();
        req_x     = {8'd4, 8'd3, 8'd2, 8'd1};
        req_valid = 4'hF;
        tick();
        wait_hs(5);
        tick();
        req_valid = 4'h0;
        check("t3_count", 32'(served_id.size()), 32'd5);
        for (int i = 0; i < 5 && i < served_id.size(); i++) begin
            check("t3_order", 32'(served_id[i]), 32'(exp_id[i]));
            check("t3_data", 32'(served_data[i]), 32'(exp_data[i]));
        end

        // 4: response back-pressure for 10 cycles, another requester waiting
        rsp_ready       = 1'b0;
        req_valid[1]    = 1'b1;
        req_x[15:8]     = 8'd3;
        wait_ready(1);
        tick();
        req_valid[1]    = 1'b0;
        req_valid[0]    = 1'b1;
        req_x[7:0]      = 8'd9;
        n = 0;
        @(negedge clk);
        while (!o_rspValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_rspv", 32'(o_rspValid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_v", 32'(o_rspValid), 32'd1);
            check("t4_hold_id", 32'(o_rspId), 32'd1);
            check("t4_hold_data", 32'(o_rspData), 32'd27);
            check("t4_no_ready", 32'(o_reqReady), 32'd0);
            check("t4_no_start", 32'(o_engStart), 32'd0);
        end
        tick();
        rsp_ready = 1'b1;
        wait_ready(0);
        tick();
        req_valid[0] = 1'b0;
        wait_hs(1);
        tick();
        check("t4_next_id", 32'(last_rsp.id), 32'd0);
        check("t4_next_data", 32'(last_rsp.data), 32'd217);

        // 5: engine never finishes -> timeout after TIMEOUT BUSY cycles
        eng_hang      = 1'b1;
        req_valid[3]  = 1'b1;
        req_x[31:24]  = 8'd5;
        wait_ready(3);
        tick();
        req_valid[3]  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_rspValid && n < 40);
        check("t5_latency", 32'(n), 32'(TIMEOUT + 2));
        tick();
        check("t5_err", 32'(last_rsp.err), 32'd1);
        check("t5_data", 32'(last_rsp.data), 32'd0);
        eng_hang = 1'b0;
        job_timed(2, 8'd6);
        check("t5_after", 32'(last_rsp.data), 32'd216);

        // 6: reset during BUSY
        req_valid[0] = 1'b1;
        req_x[7:0]   = 8'd4;
        wait_ready(0);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_in_busy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(o_busy), 32'd0);
        check("t6_start", 32'(o_engStart), 32'd0);
        check("t6_engx", 32'(o_engX), 32'd0);
        check("t6_rspv", 32'(o_rspValid), 32'd0);
        check("t6_rsp", 32'({o_rspId, o_rspData, o_rspErr}), 32'd0);
        sb_q.delete();
        ptr_model = 0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        job_timed(1, 8'd2);
        check("t6_id", 32'(last_rsp.id), 32'd1);
        check("t6_data", 32'(last_rsp.data), 32'd8);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
